// File: rtl/led_pattern_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : led_pattern_ctrl
//  Description : Pattern scheduler for a 4-LED running light. A free-running
//                prescaler produces a base tick, a divider stretches it by
//                (speed+1), and each resulting step advances the LED pattern
//                of the selected mode. Single-cycle key pulses select the mode
//                and speed and pause/resume the sequence.
//  Ports       : sys_clk    - system clock
//                sys_rst    - synchronous reset, active-high
//                mode_key   - pulse: advance mode 0..3
//                speed_key  - pulse: advance speed 0..3
//                pause_key  - pulse: toggle running
//                led_out    - registered LED pattern (1 = lit)
//                mode       - current mode
//                speed      - current speed index
//                running    - 1 = sequencing, 0 = paused
//                step_pulse - one-cycle strobe when a new step is shown
//  Revision    : 1.0 - initial release
// ============================================================================
module led_pattern_ctrl #(
  parameter int               CNT_W       = 25,
  parameter logic [CNT_W-1:0] COUNTER_MAX = CNT_W'(24_999_999)
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       mode_key,
  input  logic       speed_key,
  input  logic       pause_key,
  output logic [3:0] led_out,
  output logic [1:0] mode,
  output logic [1:0] speed,
  output logic       running,
  output logic       step_pulse
);

  localparam logic [0:0] c_dir_up   = 1'b0;
  localparam logic [0:0] c_dir_down = 1'b1;

  localparam logic [3:0] c_led_first = 4'b0001;
  localparam logic [3:0] c_led_last  = 4'b1000;
  localparam logic [3:0] c_led_all   = 4'b1111;

  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [1:0]       div_cnt_q,  div_cnt_d;
  logic [1:0]       mode_q,     mode_d;
  logic [1:0]       speed_q,    speed_d;
  logic             running_q,  running_d;
  logic [3:0]       led_q,      led_d;
  logic [0:0]       dir_q,      dir_d;
  logic             step_pulse_q, step_pulse_d;

  logic             w_any_key;
  logic             w_tick;
  logic             w_step;
  logic [1:0]       w_mode_inc;
  logic [3:0]       w_led_next;
  logic [0:0]       w_dir_next;
  logic [3:0]       w_led_init;

  assign w_any_key  = mode_key | speed_key | pause_key;
  assign w_tick     = running_q && (tick_cnt_q == COUNTER_MAX);
  // Any key pulse in the same cycle swallows the step.
  assign w_step     = w_tick && (div_cnt_q == speed_q) && !w_any_key;
  assign w_mode_inc = mode_q + 2'd1;

  // Next pattern of the current mode.
  always_comb begin
    w_led_next = led_q;
    w_dir_next = dir_q;
    case (mode_q)
      2'd0: w_led_next = {led_q[2:0], led_q[3]};
      2'd1: w_led_next = {led_q[0], led_q[3:1]};
      2'd2: begin
        // Direction flips as the end LED is reached so it is shown only once.
        if (dir_q == c_dir_up) begin
          w_led_next = {led_q[2:0], 1'b0};
          if (led_q[2]) w_dir_next = c_dir_down;
        end else begin
          w_led_next = {1'b0, led_q[3:1]};
          if (led_q[1]) w_dir_next = c_dir_up;
        end
      end
      default: w_led_next = ~led_q;
    endcase
  end

  // Initial pattern of the mode being entered on a mode_key pulse.
  always_comb begin
    w_led_init = c_led_first;
    case (w_mode_inc)
      2'd0:    w_led_init = c_led_first;
      2'd1:    w_led_init = c_led_last;
      2'd2:    w_led_init = c_led_first;
      default: w_led_init = c_led_all;
    endcase
  end

  always_comb begin
    tick_cnt_d   = tick_cnt_q;
    div_cnt_d    = div_cnt_q;
    mode_d       = mode_q;
    speed_d      = speed_q;
    running_d    = running_q;
    led_d        = led_q;
    dir_d        = dir_q;
    step_pulse_d = w_step;

    // Timing only advances on quiet running cycles; a lone pause_key edge
    // holds the counts so resume continues exactly where it left off.
    if (running_q && !w_any_key) begin
      if (w_tick) begin
        tick_cnt_d = '0;
        div_cnt_d  = (div_cnt_q == speed_q) ? 2'd0 : div_cnt_q + 2'd1;
      end else begin
        tick_cnt_d = tick_cnt_q + CNT_W'(1);
      end
      if (w_step) begin
        led_d = w_led_next;
        dir_d = w_dir_next;
      end
    end

    if (mode_key) begin
      mode_d = w_mode_inc;
      led_d  = w_led_init;
      dir_d  = c_dir_up;
    end
    if (speed_key) begin
      speed_d = speed_q + 2'd1;
    end
    if (mode_key || speed_key) begin
      tick_cnt_d = '0;
      div_cnt_d  = 2'd0;
    end
    if (pause_key) begin
      running_d = !running_q;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      tick_cnt_q   <= '0;
      div_cnt_q    <= 2'd0;
      mode_q       <= 2'd0;
      speed_q      <= 2'd0;
      running_q    <= 1'b1;
      led_q        <= c_led_first;
      dir_q        <= c_dir_up;
      step_pulse_q <= 1'b0;
    end else begin
      tick_cnt_q   <= tick_cnt_d;
      div_cnt_q    <= div_cnt_d;
      mode_q       <= mode_d;
      speed_q      <= speed_d;
      running_q    <= running_d;
      led_q        <= led_d;
      dir_q        <= dir_d;
      step_pulse_q <= step_pulse_d;
    end
  end

  assign led_out    = led_q;
  assign mode       = mode_q;
  assign speed      = speed_q;
  assign running    = running_q;
  assign step_pulse = step_pulse_q;

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_pattern_ctrl
//  Description : Self-checking bench for led_pattern_ctrl with a small
//                prescaler: a table of key-pulse vectors, hand-written timing
//                sequences, and random keys against a reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_pattern_ctrl;

  localparam int CNT_W = 25;
  localparam int MAX   = 24;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       mode_key = 1'b0;
  logic       speed_key = 1'b0;
  logic       pause_key = 1'b0;
  logic [3:0] led_out;
  logic [1:0] mode;
  logic [1:0] speed;
  logic       running;
  logic       step_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pattern position within the mode's sequence and the
  // number of running cycles elapsed in the current step period.
  int m_mode, m_speed, m_pos, m_phase;
  bit m_run, m_sp;

  led_pattern_ctrl #(
    .CNT_W      (CNT_W),
    .COUNTER_MAX(25'd24)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .mode_key  (mode_key),
    .speed_key (speed_key),
    .pause_key (pause_key),
    .led_out   (led_out),
    .mode      (mode),
    .speed     (speed),
    .running   (running),
    .step_pulse(step_pulse)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic int plen(input int md);
    case (md)
      0, 1:    return 4;
      2:       return 6;
      default: return 2;
    endcase
  endfunction

  function automatic logic [3:0] pat(input int md, input int p);
    case (md)
      0:       return 4'(1 << p);
      1:       return 4'(8 >> p);
      2:       return (p < 4) ? 4'(1 << p) : 4'(1 << (6 - p));
      default: return (p == 0) ? 4'hF : 4'h0;
    endcase
  endfunction

  task automatic model_step(input bit rs, input bit mk, input bit sk, input bit pk);
    bit quiet;
    if (rs) begin
      m_mode = 0; m_speed = 0; m_pos = 0; m_phase = 0; m_run = 1; m_sp = 0;
    end else begin
      quiet = m_run && !(mk || sk || pk);
      m_sp  = quiet && (m_phase == (m_speed + 1) * (MAX + 1) - 1);
      if (m_sp) begin
        m_pos   = (m_pos + 1) % plen(m_mode);
        m_phase = 0;
      end else if (quiet) begin
        m_phase = m_phase + 1;
      end
      if (mk) begin
        m_mode = (m_mode + 1) % 4;
        m_pos  = 0;
      end
      if (sk) m_speed = (m_speed + 1) % 4;
      if (mk || sk) m_phase = 0;
      if (pk) m_run = !m_run;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs at the falling edge, advance the model with the
  // same inputs at the rising edge, compare all outputs 1 ns later.
  task automatic cyc(input bit rs, input bit mk, input bit sk, input bit pk);
    @(negedge sys_clk);
    sys_rst = rs; mode_key = mk; speed_key = sk; pause_key = pk;
    @(posedge sys_clk);
    model_step(rs, mk, sk, pk);
    #1;
    chk("model {led,mode,speed,run,step}",
        {21'd0, led_out, mode, speed, running, step_pulse},
        {21'd0, pat(m_mode, m_pos), 2'(m_mode), 2'(m_speed), m_run, m_sp});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
  endtask

  typedef struct {
    bit         rs, mk, sk, pk;
    logic [3:0] led;
    logic [1:0] md, sp;
    logic       run;
  } vec_t;

  vec_t tbl[13];
  logic [3:0] pp_seq[7];

  initial begin
    tbl[0]  = '{1, 0, 0, 0, 4'b0001, 2'd0, 2'd0, 1'b1};
    tbl[1]  = '{0, 1, 0, 0, 4'b1000, 2'd1, 2'd0, 1'b1};
    tbl[2]  = '{0, 1, 1, 0, 4'b0001, 2'd2, 2'd1, 1'b1};
    tbl[3]  = '{0, 0, 1, 0, 4'b0001, 2'd2, 2'd2, 1'b1};
    tbl[4]  = '{0, 1, 0, 0, 4'b1111, 2'd3, 2'd2, 1'b1};
    tbl[5]  = '{0, 0, 0, 1, 4'b1111, 2'd3, 2'd2, 1'b0};
    tbl[6]  = '{0, 1, 0, 1, 4'b0001, 2'd0, 2'd2, 1'b1};
    tbl[7]  = '{0, 0, 1, 0, 4'b0001, 2'd0, 2'd3, 1'b1};
    tbl[8]  = '{0, 0, 1, 0, 4'b0001, 2'd0, 2'd0, 1'b1};
    tbl[9]  = '{1, 1, 0, 0, 4'b0001, 2'd0, 2'd0, 1'b1};
    tbl[10] = '{0, 0, 1, 1, 4'b0001, 2'd0, 2'd1, 1'b0};
    tbl[11] = '{0, 0, 0, 1, 4'b0001, 2'd0, 2'd1, 1'b1};
    tbl[12] = '{1, 0, 0, 1, 4'b0001, 2'd0, 2'd0, 1'b1};
    pp_seq  = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};

    model_step(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("reset led", led_out, 4'b0001);
    chk("reset step_pulse", step_pulse, 1'b0);
    chk("reset running", running, 1'b1);

    // Key-pulse vectors: no step can occur within this short window.
    for (int i = 0; i < 13; i++) begin
      cyc(tbl[i].rs, tbl[i].mk, tbl[i].sk, tbl[i].pk);
      chk($sformatf("vec%0d led", i), led_out, tbl[i].led);
      chk($sformatf("vec%0d mode", i), mode, tbl[i].md);
      chk($sformatf("vec%0d speed", i), speed, tbl[i].sp);
      chk($sformatf("vec%0d running", i), running, tbl[i].run);
      chk($sformatf("vec%0d step_pulse", i), step_pulse, 1'b0);
    end

    // Base rotation: one step every 25 cycles.
    cyc(1, 0, 0, 0);
    idle(24);
    chk("t1 before first step", {led_out, step_pulse}, {4'b0001, 1'b0});
    idle(1);
    chk("t1 first step", {led_out, step_pulse}, {4'b0010, 1'b1});
    idle(1);
    chk("t1 pulse width", step_pulse, 1'b0);
    idle(24);
    chk("t1 step2", led_out, 4'b0100);
    idle(25);
    chk("t1 step3", led_out, 4'b1000);
    idle(25);
    chk("t1 step4 wrap", led_out, 4'b0001);

    // Speed 2: 75-cycle period counted from the key edge, then wrap to 0.
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    chk("t2 speed", speed, 2'd2);
    idle(74);
    chk("t2 no early step", {led_out, step_pulse}, {4'b0001, 1'b0});
    idle(1);
    chk("t2 slow step", {led_out, step_pulse}, {4'b0010, 1'b1});
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    chk("t2 speed wrap", speed, 2'd0);
    idle(24);
    chk("t2 no step at 24", led_out, 4'b0010);
    idle(1);
    chk("t2 fast step", led_out, 4'b0100);

    // Ping-pong and blink.
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    chk("t3 mode2", {mode, led_out}, {2'd2, 4'b0001});
    for (int i = 0; i < 7; i++) begin
      idle(25);
      chk($sformatf("t3 pingpong step%0d", i), led_out, pp_seq[i]);
    end
    cyc(0, 1, 0, 0);
    chk("t3 mode3", {mode, led_out}, {2'd3, 4'b1111});
    idle(25);
    chk("t3 blink off", led_out, 4'b0000);
    idle(25);
    chk("t3 blink on", led_out, 4'b1111);

    // Pause at tick count 10, hold 100 cycles, resume with 15 cycles left.
    cyc(1, 0, 0, 0);
    idle(10);
    cyc(0, 0, 0, 1);
    chk("t4 paused", running, 1'b0);
    for (int i = 0; i < 100; i++) begin
      idle(1);
      chk("t4 frozen", {led_out, step_pulse}, {4'b0001, 1'b0});
    end
    cyc(0, 0, 0, 1);
    chk("t4 resumed", running, 1'b1);
    idle(14);
    chk("t4 no step at 14", {led_out, step_pulse}, {4'b0001, 1'b0});
    idle(1);
    chk("t4 step at 15", {led_out, step_pulse}, {4'b0010, 1'b1});

    // mode_key on the step-condition cycle suppresses the step.
    cyc(1, 0, 0, 0);
    idle(24);
    cyc(0, 1, 0, 0);
    chk("t5 mode1 load", {mode, led_out, step_pulse}, {2'd1, 4'b1000, 1'b0});
    idle(24);
    chk("t5 no step at 24", led_out, 4'b1000);
    idle(1);
    chk("t5 step", {led_out, step_pulse}, {4'b0100, 1'b1});

    // Reset mid-sequence while paused, with a coincident mode_key.
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 1);
    chk("t6 pre-reset", {mode, speed, running}, {2'd2, 2'd3, 1'b0});
    cyc(1, 1, 0, 0);
    chk("t6 post-reset", {mode, speed, running, led_out}, {2'd0, 2'd0, 1'b1, 4'b0001});

    // Random key traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 59) == 0,
          $urandom_range(0, 59) == 0, $urandom_range(0, 79) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/led_pattern_ctrl.md
Name: led_pattern_ctrl

Overview:
Pattern scheduler for the 4-LED running-light datapath on the YeHuo board. It keeps a free-running prescaler, sequences the LED pattern, and lets three single-cycle key pulses select the pattern mode, select the step speed, and pause or resume the sequence. It sits between the key debounce blocks and the board LED pins, and replaces the fixed single-mode water-light counter.

Parameters:
COUNTER_MAX, 25'd24_999_999, prescaler terminal count; base tick period = COUNTER_MAX+1 sys_clk cycles (sims use 25'd24)
CNT_W, 25, prescaler counter width; COUNTER_MAX must fit in CNT_W bits

Ports:
sys_clk     input   1   system clock, 50 MHz
sys_rst     input   1   synchronous reset, active-high
mode_key    input   1   one-cycle pulse: advance mode 0→1→2→3→0
speed_key   input   1   one-cycle pulse: advance speed 0→1→2→3→0
pause_key   input   1   one-cycle pulse: toggle running
led_out     output  4   LED pattern, registered, bit=1 means LED lit
mode        output  2   current mode
speed       output  2   current speed index
running     output  1   1 = sequencing, 0 = paused
step_pulse  output  1   one-cycle strobe, high in the cycle led_out first shows a new step pattern

Behaviour:
- Single clock domain. All state is updated on the sys_clk rising edge.
- Reset (sys_rst=1 at the edge): mode=0, speed=0, running=1, led_out=4'b0001, dir=up, tick_cnt=0, div_cnt=0, step_pulse=0. Reset overrides all key inputs. Reset mid-sequence restarts the full timing from zero.
- Prescaler: when running, tick_cnt counts 0..COUNTER_MAX and wraps to 0. tick = running && tick_cnt==COUNTER_MAX.
- Divider: div_cnt increments on each tick and wraps to 0 after reaching speed.
- Step condition: tick && div_cnt==speed, with no key pulse in the same cycle.
  - Step period = (speed+1)*(COUNTER_MAX+1) cycles.
- On a step edge, led_out loads its next value. step_pulse=1 in the following cycle only.
- Patterns, initial value then sequence:
  - mode0, rotate left: 0001→0010→0100→1000→0001.
  - mode1, rotate right: 1000→0100→0010→0001→1000.
  - mode2, ping-pong: 0001→0010→0100→1000→0100→0010→0001→…
    - dir flips to down on reaching 1000 and to up on reaching 0001. The end LEDs are not repeated.
  - mode3, blink: 1111↔0000.
- mode_key: mode advances (3 wraps to 0). led_out loads the new mode's initial value, dir=up, tick_cnt=0, div_cnt=0. running is unchanged.
- speed_key: speed advances (3 wraps to 0), tick_cnt=0, div_cnt=0. led_out is unchanged.
- pause_key: running toggles.
  - While paused, tick_cnt, div_cnt and led_out hold, and step_pulse=0.
  - Resume continues from the held counts. No restart, no extra step.
- Simultaneous events, applied in the same edge:
  - mode_key and speed_key together: both advance; led_out loads the initial value of the new mode.
  - Any key pulse suppresses a coincident step: no led_out advance and no step_pulse.
  - pause_key with mode_key or speed_key: all take effect. A mode change while paused still loads the initial pattern.
  - Key pulses during reset are ignored.
- A key held high for N cycles counts as N pulses. The debouncer guarantees single-cycle pulses.
- Latency: key pulse → mode/speed/running/led_out updated at the same edge (visible next cycle).

Test Plan:
1. Reset, then release at t=20 ns with COUNTER_MAX=24 → led_out=0001. The first step comes 25 cycles later → 0010 with step_pulse high for one cycle. Steps continue every 25 cycles: 0100, 1000, 0001.
2. speed_key ×2 → speed=2; steps every 75 cycles, counted from the key edge. Then speed_key ×2 more → speed wraps to 0 and the period returns to 25.
3. mode_key ×2 → mode=2, led_out=0001. Sequence over 7 steps = 0010,0100,1000,0100,0010,0001,0010. mode_key again → mode=3, led_out=1111, then 0000, then 1111.
4. pause_key at tick_cnt=10 → running=0; led_out frozen for 100 cycles, no step_pulse. pause_key again → next step arrives exactly 15 cycles after resume.
5. mode_key on the exact step-condition cycle → mode=1, led_out=1000, no step_pulse. The next step comes 25 cycles later → 0100.
6. sys_rst=1 mid-sequence (mode=2, speed=3, paused) → next cycle: mode=0, speed=0, running=1, led_out=0001. A mode_key asserted during reset has no effect.
